multicycle_control_unit: RTL and testbench

- Multi-cycle RV32I control FSM. It drives the ALU control inputs (func, sub_sra, operand selects) and consumes the ALU comparator flags (EQ, LU, LS) to resolve branches.
- It sequences fetch/decode/execute/memory/writeback over a shared handshaked memory port and steers the datapath muxes and write enables.
- It sits between the instruction register, register file, PC logic and ALU. It is the producer of the ALU's control interface.

---
 rtl/multicycle_control_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over one handshaked memory port and drives ALU, PC, IR and register-file controls.
module multicycle_control_unit #(
  parameter int CNT_W           = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             EQ,
  input  logic             LU,
  input  logic             LS,
  output logic [2:0]       alu_func,
  output logic             alu_sub_sra,
  output logic [1:0]       alu_a_sel,
  output logic             alu_b_sel,
  output logic [2:0]       imm_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             mem_req,
  output logic             mem_we,
  output logic [2:0]       mem_size,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd7
  } state_t;

  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  state_t state, next_state;
  logic   retire, set_ill;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5, legal, taken, is_store;
  logic       instr_unused;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign f7b5         = instr[30];
  assign is_store     = (opcode == OP_STORE);
  assign instr_unused = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      OP_BR:   legal = (funct3[2:1] != 2'b01);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = EQ;
      3'b001:  taken = !EQ;
      3'b100:  taken = LS;
      3'b101:  taken = !LS;
      3'b110:  taken = LU;
      3'b111:  taken = !LU;
      default: taken = 1'b0;
    endcase
  end

  // Per-instruction datapath steering; applied from EXECUTE through WRITEBACK
  // so the ALU result and immediate stay valid until the register write.
  logic [2:0] d_func, d_imm;
  logic       d_sub, d_b;
  logic [1:0] d_a, d_wb;

  always_comb begin
    d_func = 3'd0;
    d_sub  = 1'b0;
    d_a    = 2'd0;
    d_b    = 1'b0;
    d_imm  = 3'd0;
    d_wb   = 2'd0;
    case (opcode)
      OP_OP: begin
        d_func = funct3;
        d_sub  = (funct3 == 3'b000 || funct3 == 3'b101) ? f7b5 : (funct3[2:1] == 2'b01);
      end
      OP_IMM: begin
        d_func = funct3;
        d_b    = 1'b1;
        d_sub  = (funct3 == 3'b101) ? f7b5 : (funct3[2:1] == 2'b01);
      end
      OP_LOAD:  begin d_b = 1'b1; d_wb = 2'd1; end
      OP_STORE: begin d_b = 1'b1; d_imm = 3'd1; end
      OP_BR:    begin d_sub = 1'b1; d_imm = 3'd2; end
      OP_JAL:   begin d_imm = 3'd4; d_wb = 2'd2; end
      OP_JALR:  begin d_b = 1'b1; d_wb = 2'd2; end
      OP_LUI:   begin d_imm = 3'd3; d_wb = 2'd3; end
      OP_AUIPC: begin d_a = 2'd1; d_b = 1'b1; d_imm = 3'd3; end
      default:  ;
    endcase
  end

  always_comb begin
    next_state  = state;
    retire      = 1'b0;
    set_ill     = 1'b0;
    alu_func    = 3'd0;
    alu_sub_sra = 1'b0;
    alu_a_sel   = 2'd0;
    alu_b_sel   = 1'b0;
    imm_sel     = 3'd0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_sel      = 2'd0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_size    = 3'd0;
    reg_write   = 1'b0;
    wb_sel      = 2'd0;

    if (state inside {S_EXECUTE, S_MEMORY, S_WRITEBACK}) begin
      alu_func    = d_func;
      alu_sub_sra = d_sub;
      alu_a_sel   = d_a;
      alu_b_sel   = d_b;
      imm_sel     = d_imm;
      wb_sel      = d_wb;
    end

    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_size = 3'b010;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal) next_state = S_EXECUTE;
        else begin
          set_ill    = 1'b1;
          next_state = HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;
        end
      end
      S_EXECUTE: begin
        case (opcode)
          OP_BR: begin
            pc_sel     = 2'd1;
            pc_write   = taken;
            retire     = 1'b1;
            next_state = S_FETCH;
          end
          OP_LOAD, OP_STORE: next_state = S_MEMORY;
          OP_JAL:  begin pc_write = 1'b1; pc_sel = 2'd1; next_state = S_WRITEBACK; end
          OP_JALR: begin pc_write = 1'b1; pc_sel = 2'd2; next_state = S_WRITEBACK; end
          default: next_state = S_WRITEBACK;
        endcase
      end
      S_MEMORY: begin
        mem_req  = 1'b1;
        mem_we   = is_store;
        mem_size = funct3;
        if (mem_ready) begin
          retire     = is_store;
          next_state = is_store ? S_FETCH : S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase

    // Controls are silenced for the whole reset pulse, including the FETCH request.
    if (reset) begin
      alu_func    = 3'd0;
      alu_sub_sra = 1'b0;
      alu_a_sel   = 2'd0;
      alu_b_sel   = 1'b0;
      imm_sel     = 3'd0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_sel      = 2'd0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_size    = 3'd0;
      reg_write   = 1'b0;
      wb_sel      = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
      instret <= '0;
    end else begin
      state   <= next_state;
      illegal <= illegal | set_ill;
      instret <= instret + CNT_W'(retire);
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: the driver pushes one expected control snapshot per cycle,
// a negedge monitor pops and compares it against the live outputs.
module tb_multicycle_control_unit;

  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0, EQ = 1'b0, LU = 1'b0, LS = 1'b0;
  logic [2:0]  alu_func, imm_sel, mem_size, state_out;
  logic        alu_sub_sra, alu_b_sel, ir_write, pc_write, mem_req, mem_we, reg_write, illegal;
  logic [1:0]  alu_a_sel, pc_sel, wb_sel;
  logic [31:0] instret;

  multicycle_control_unit #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .EQ(EQ), .LU(LU), .LS(LS),
    .alu_func(alu_func), .alu_sub_sra(alu_sub_sra), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .imm_sel(imm_sel), .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .reg_write(reg_write),
    .wb_sel(wb_sel), .illegal(illegal), .instret(instret), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  tag;
    logic [2:0]  st;
    logic        req, we, irw, pcw, rw, ill, all, chk_alu, chk_imm;
    logic [2:0]  msize;
    logic [1:0]  psel, wsel;
    logic [2:0]  func;
    logic        sub;
    logic [1:0]  a;
    logic        b;
    logic [2:0]  imm;
    logic [31:0] ir;
  } exp_t;

  localparam int K_OP = 0, K_OPI = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5,
                 K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_ILL = 9;

  exp_t        q[$];
  int          vectors = 0, miscompares = 0;
  logic [31:0] model_ret = '0;
  logic        model_ill = 1'b0;

  function automatic string tag_name(logic [3:0] t);
    case (t)
      4'd0: return "reset";    4'd1: return "fetch_wait"; 4'd2: return "fetch";
      4'd3: return "decode";   4'd4: return "execute";    4'd5: return "mem_wait";
      4'd6: return "memory";   4'd7: return "writeback";  4'd8: return "trap";
      default: return "other";
    endcase
  endfunction

  function automatic int kind_of(logic [31:0] i);
    case (i[6:0])
      7'b0110011: return K_OP;
      7'b0010011: return K_OPI;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b1100011: return (i[14:13] == 2'b01) ? K_ILL : K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic bit br_taken(logic [2:0] f3, logic eq, logic lu, logic ls);
    case (f3)
      3'd0: return eq;   3'd1: return !eq;
      3'd4: return ls;   3'd5: return !ls;
      3'd6: return lu;   3'd7: return !lu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t blank(logic [3:0] t, logic [2:0] s);
    exp_t e;
    e     = '0;
    e.tag = t;
    e.st  = s;
    e.ir  = model_ret;
    e.ill = model_ill;
    return e;
  endfunction

  // Expected ALU/immediate/writeback steering for an instruction class.
  function automatic exp_t with_ctl(exp_t e0, logic [31:0] ins, int k);
    exp_t e;
    logic [2:0] f3;
    e  = e0;
    f3 = ins[14:12];
    e.chk_alu = 1'b1;
    e.chk_imm = 1'b1;
    case (k)
      K_OP: begin
        e.func = f3;
        if (f3 == 3'd0 || f3 == 3'd5) e.sub = ins[30];
        else e.sub = (f3 == 3'd2 || f3 == 3'd3);
        e.wsel = 2'd0;
      end
      K_OPI: begin
        e.func = f3; e.b = 1'b1;
        if (f3 == 3'd5) e.sub = ins[30];
        else e.sub = (f3 == 3'd2 || f3 == 3'd3);
        e.wsel = 2'd0;
      end
      K_LD:    begin e.b = 1'b1; e.imm = 3'd0; e.wsel = 2'd1; end
      K_ST:    begin e.b = 1'b1; e.imm = 3'd1; end
      K_BR:    begin e.sub = 1'b1; e.imm = 3'd2; end
      K_JAL:   begin e.chk_alu = 1'b0; e.imm = 3'd4; e.wsel = 2'd2; end
      K_JALR:  begin e.b = 1'b1; e.imm = 3'd0; e.wsel = 2'd2; end
      K_LUI:   begin e.chk_alu = 1'b0; e.imm = 3'd3; e.wsel = 2'd3; end
      K_AUIPC: begin e.a = 2'd1; e.b = 1'b1; e.imm = 3'd3; e.wsel = 2'd0; end
      default: begin e.chk_alu = 1'b0; e.chk_imm = 1'b0; end
    endcase
    return e;
  endfunction

  // Monitor: one expected snapshot per cycle, sampled mid-cycle.
  exp_t me;
  logic bad;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me  = q.pop_front();
      bad = 1'b0;
      vectors++;
      if (state_out !== me.st || mem_req !== me.req || mem_we !== me.we || ir_write !== me.irw ||
          pc_write !== me.pcw || reg_write !== me.rw || illegal !== me.ill || instret !== me.ir)
        bad = 1'b1;
      if (me.req && mem_size !== me.msize) bad = 1'b1;
      if (me.pcw && pc_sel !== me.psel) bad = 1'b1;
      if (me.rw && wb_sel !== me.wsel) bad = 1'b1;
      if (me.chk_alu && {alu_func, alu_sub_sra, alu_a_sel, alu_b_sel} !== {me.func, me.sub, me.a, me.b})
        bad = 1'b1;
      if (me.chk_imm && imm_sel !== me.imm) bad = 1'b1;
      if (me.all && {pc_sel, wb_sel, mem_size} !== '0) bad = 1'b1;
      if (bad) begin
        miscompares++;
        $display("FAIL %s @%0t instr=%h: got st=%0d req=%b we=%b sz=%0d irw=%b pcw=%b psel=%0d rw=%b wsel=%0d func=%0d sub=%b a=%0d b=%b imm=%0d ill=%b ret=%0d; want st=%0d req=%b we=%b sz=%0d irw=%b pcw=%b psel=%0d rw=%b wsel=%0d func=%0d sub=%b a=%0d b=%b imm=%0d ill=%b ret=%0d",
          tag_name(me.tag), $time, instr,
          state_out, mem_req, mem_we, mem_size, ir_write, pc_write, pc_sel, reg_write, wb_sel,
          alu_func, alu_sub_sra, alu_a_sel, alu_b_sel, imm_sel, illegal, instret,
          me.st, me.req, me.we, me.msize, me.irw, me.pcw, me.psel, me.rw, me.wsel,
          me.func, me.sub, me.a, me.b, me.imm, me.ill, me.ir);
      end
    end
  end

  task automatic step(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_flags();
    {EQ, LU, LS} = 3'($urandom);
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    reset     = 1'b1;
    model_ret = '0;
    model_ill = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom);
      e = blank(4'd0, 3'd0);
      e.all = 1'b1; e.chk_alu = 1'b1; e.chk_imm = 1'b1;
      step(e);
    end
    reset = 1'b0;
  endtask

  // flg < 0 randomizes {EQ,LU,LS} in EXECUTE; abort resets after the memory stalls.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input int flg, input bit abort);
    exp_t e;
    int k;
    logic [2:0] f3;
    k  = kind_of(ins);
    f3 = ins[14:12];
    for (int i = 0; i < fw; i++) begin
      mem_ready = 1'b0; instr = $urandom; rnd_flags();
      e = blank(4'd1, 3'd0); e.req = 1'b1; e.msize = 3'b010;
      step(e);
    end
    mem_ready = 1'b1; instr = $urandom;
    e = blank(4'd2, 3'd0); e.req = 1'b1; e.msize = 3'b010; e.irw = 1'b1; e.pcw = 1'b1; e.psel = 2'd0;
    step(e);
    instr = ins; mem_ready = 1'($urandom);
    e = blank(4'd3, 3'd1);
    step(e);
    if (k == K_ILL) begin
      model_ill = 1'b1;
      for (int i = 0; i < 3; i++) begin
        mem_ready = 1'($urandom); rnd_flags();
        e = blank(4'd8, 3'd7);
        step(e);
      end
      return;
    end
    mem_ready = 1'($urandom); rnd_flags();
    if (flg >= 0) {EQ, LU, LS} = 3'(flg);
    e = with_ctl(blank(4'd4, 3'd2), ins, k);
    if (k == K_BR) begin
      e.pcw = br_taken(f3, EQ, LU, LS); e.psel = 2'd1;
      step(e);
      model_ret++;
      return;
    end
    if (k == K_JAL)  begin e.pcw = 1'b1; e.psel = 2'd1; end
    if (k == K_JALR) begin e.pcw = 1'b1; e.psel = 2'd2; end
    step(e);
    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i < mw; i++) begin
        mem_ready = 1'b0; rnd_flags();
        e = blank(4'd5, 3'd3); e.req = 1'b1; e.we = (k == K_ST); e.msize = f3;
        step(e);
      end
      if (abort) begin
        do_reset(2);
        return;
      end
      mem_ready = 1'b1;
      e = blank(4'd6, 3'd3); e.req = 1'b1; e.we = (k == K_ST); e.msize = f3;
      step(e);
      if (k == K_ST) begin
        model_ret++;
        return;
      end
    end
    mem_ready = 1'($urandom);
    e = with_ctl(blank(4'd7, 3'd4), ins, k);
    e.rw = 1'b1;
    step(e);
    model_ret++;
  endtask

  logic [6:0] op_tab [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};

  initial begin
    logic [31:0] r;
    @(posedge clk);
    #1;
    do_reset(3);
    run_instr(32'h402081B3, 0, 0, -1, 1'b0);        // SUB x3,x1,x2
    run_instr(32'h0020E063, 0, 0, 3'b010, 1'b0);    // BLTU, LU=1 -> taken
    run_instr(32'h0020E063, 0, 0, 3'b101, 1'b0);    // BLTU, LU=0 -> not taken
    run_instr(32'h0000A183, 2, 3, -1, 1'b0);        // LW with stalls
    run_instr(32'h4010D093, 1, 0, -1, 1'b0);        // SRAI
    run_instr(32'h40008093, 0, 0, -1, 1'b0);        // ADDI, imm bit10 set
    run_instr(32'h0020A023, 0, 2, -1, 1'b1);        // SW aborted by reset in MEMORY
    run_instr(32'h0020A023, 1, 1, -1, 1'b0);        // SW completes
    run_instr(32'h0000006F, 0, 0, -1, 1'b0);        // JAL
    run_instr(32'h00008067, 0, 0, -1, 1'b0);        // JALR
    run_instr(32'h123450B7, 0, 0, -1, 1'b0);        // LUI
    run_instr(32'h00001097, 0, 0, -1, 1'b0);        // AUIPC
    run_instr(32'h0000007F, 0, 0, -1, 1'b0);        // illegal -> TRAP
    do_reset(2);
    run_instr(32'h0020A063, 0, 0, -1, 1'b0);        // branch funct3=010 -> TRAP
    do_reset(1);
    for (int n = 0; n < 160; n++) begin
      r = $urandom;
      run_instr({r[31:7], op_tab[$urandom_range(0, 9)]}, $urandom_range(0, 2),
                $urandom_range(0, 2), -1, 1'b0);
      if (model_ill) do_reset(1);
    end
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected snapshots left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
